sevenseg_ctrl: RTL and testbench

Memory-mapped scan controller for the three-digit seven-segment display on the PicoSoC iomem bus. Firmware writes hex digit values, decimal points and enable through registers; the block time-multiplexes the shared segment lines across the three digit enables. It includes anti-ghosting gaps and tear-free digit updates. It sits beside the UART and VGA peripherals and drives the top-level seven-segment segment and enable pins directly.

---
 rtl/sevenseg_pkg.sv | 24 ++
 rtl/sevenseg_font.sv | 32 +++
 rtl/sevenseg_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_sevenseg_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared definitions for the three-digit seven-segment scan
// controller.
//   - register word offsets inside the 16-byte iomem window
//   - scan FSM state encoding
//   - CTRL field positions and the CTRL reset constant
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_DP_LSB = 1;
  localparam int unsigned CTRL_BR_LSB = 4;

  localparam logic [31:0] CTRL_RESET = 32'h0000_00F0;

endpackage

// File: rtl/sevenseg_font.sv
// sevenseg_font: hex digit to seven-segment pattern.
//   nibble  in  4  hex value 0-F
//   seg     out 7  active-high segments, bit0=a ... bit6=g
module sevenseg_font (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/sevenseg_ctrl.sv
// sevenseg_ctrl: memory-mapped scan controller for a three-digit
// seven-segment display on the PicoSoC iomem bus.
//   clk          in  1   system clock
//   resetn       in  1   asynchronous active-low reset
//   iomem_valid  in  1   bus request
//   iomem_ready  out 1   one-cycle acknowledge
//   iomem_wstrb  in  4   byte write strobes, 0 = read
//   iomem_addr   in  32  byte address (window decoded on [31:4])
//   iomem_wdata  in  32  write data
//   iomem_rdata  out 32  read data, valid with iomem_ready
//   ss           out 8   segments, active-low, bit7 = dp
//   ssen         out 3   digit enables, active-low, ssen[0] rightmost
// Registers: 0x0 DATA[11:0], 0x4 CTRL{bright[7:4],dp[3:1],en[0]},
//            0x8 STATUS{in_gap[2],digit[1:0]}, 0xC reserved.
// Build option: SEVENSEG_BRIGHTNESS_EN adds a per-DRIVE 4-bit phase counter
// that gates the digit enable by CTRL brightness; without it the
// brightness field is not stored and reads 0.
module sevenseg_ctrl
  import sevenseg_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR    = 32'h0300_0000,
  parameter int unsigned  DIGIT_CYCLES = 100000,
  parameter int unsigned  GAP_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  ss,
  output logic [2:0]  ssen
);

  localparam int unsigned CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

`ifdef SEVENSEG_BRIGHTNESS_EN
  localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

  // ---------------- bus register file ----------------
  logic        ready_q;
  logic        acked_q;
  logic [31:0] rdata_q;
  logic [11:0] data_q;
  logic [7:0]  ctrl_q;
  logic        hit;
  logic [3:0]  word_off;
  logic [31:0] rd_val;

  state_t      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        load_shadow;

  logic        ctrl_en;
  logic [2:0]  ctrl_dp;

  assign ctrl_en  = ctrl_q[CTRL_EN_BIT];
  assign ctrl_dp  = ctrl_q[CTRL_DP_LSB +: 3];
  assign word_off = {iomem_addr[3:2], 2'b00};

  // acked_q holds off a second acknowledge while the master keeps valid
  // asserted after the transfer completed.
  assign hit = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4])
               && !ready_q && !acked_q;

  always_comb begin
    rd_val = '0;
    case (word_off)
      OFF_DATA:   rd_val = {20'd0, data_q};
      OFF_CTRL:   rd_val = {24'd0, ctrl_q};
      OFF_STATUS: rd_val = {29'd0, (state_q == ST_GAP), digit_q};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      acked_q <= 1'b0;
      rdata_q <= '0;
      data_q  <= '0;
      ctrl_q  <= CTRL_RESET[7:0] & CTRL_WMASK;
    end else begin
      ready_q <= hit;
      acked_q <= iomem_valid && (acked_q || hit);
      rdata_q <= hit ? rd_val : '0;
      if (hit && (iomem_wstrb != 4'b0000)) begin
        if (word_off == OFF_DATA) begin
          if (iomem_wstrb[0]) data_q[7:0]  <= iomem_wdata[7:0];
          if (iomem_wstrb[1]) data_q[11:8] <= iomem_wdata[11:8];
        end else if (word_off == OFF_CTRL) begin
          if (iomem_wstrb[0]) ctrl_q <= iomem_wdata[7:0] & CTRL_WMASK;
        end
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

  logic unused_bus;
  assign unused_bus = ^{iomem_wdata[31:12], iomem_wstrb[3:2], iomem_addr[1:0]};

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      digit_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q + 1'b1;
    load_shadow = 1'b0;
    if (!ctrl_en) begin
      state_d = ST_IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_DRIVE;
          digit_d     = '0;
          cnt_d       = '0;
          load_shadow = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            if (digit_q == 2'd2) begin
              digit_d     = '0;
              load_shadow = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          digit_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow copy taken only on digit-0 DRIVE entry so a frame never mixes
  // two DATA writes.
  logic [11:0] shadow_data;
  logic [2:0]  shadow_dp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (load_shadow) begin
      shadow_data <= data_q;
      shadow_dp   <= ctrl_dp;
    end
  end

  // ---------------- brightness phase ----------------
  logic lit;

`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0] phase_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      phase_q <= '0;
    else if (state_d == ST_DRIVE && state_q == ST_DRIVE)
      phase_q <= phase_q + 1'b1;
    else
      phase_q <= '0;
  end

  assign lit = (state_q == ST_DRIVE) && (phase_q <= ctrl_q[CTRL_BR_LSB +: 4]);
`else
  assign lit = (state_q == ST_DRIVE);
`endif

  // ---------------- output stage ----------------
  logic [3:0] nibble;
  logic       dp_sel;
  logic [6:0] seg;

  always_comb begin
    nibble = shadow_data[3:0];
    dp_sel = shadow_dp[0];
    case (digit_q)
      2'd1: begin
        nibble = shadow_data[7:4];
        dp_sel = shadow_dp[1];
      end
      2'd2: begin
        nibble = shadow_data[11:8];
        dp_sel = shadow_dp[2];
      end
      default: begin
        nibble = shadow_data[3:0];
        dp_sel = shadow_dp[0];
      end
    endcase
  end

  sevenseg_font u_font (
    .nibble (nibble),
    .seg    (seg)
  );

  // Pins register the decoded current state; clearing enable forces blank
  // on the very next edge instead of waiting for the FSM to reach IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ss   <= '1;
      ssen <= '1;
    end else if (!ctrl_en || state_q != ST_DRIVE) begin
      ss   <= '1;
      ssen <= '1;
    end else begin
      ss   <= ~{dp_sel, seg};
      ssen <= lit ? ~(3'b001 << digit_q) : 3'b111;
    end
  end

endmodule

// File: tb/tb_sevenseg_ctrl.sv
module tb_sevenseg_ctrl;

  localparam logic [31:0] BASE = 32'h0300_0000;

`ifdef SEVENSEG_BRIGHTNESS_EN
  localparam bit BR_BUILT = 1'b1;
`else
  localparam bit BR_BUILT = 1'b0;
`endif
  localparam logic [31:0] CTRL_RST_EXP = BR_BUILT ? 32'h0000_00F0 : 32'h0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [7:0]  ss;
  logic [2:0]  ssen;

  sevenseg_ctrl #(
    .BASE_ADDR    (BASE),
    .DIGIT_CYCLES (8),
    .GAP_CYCLES   (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .ss          (ss),
    .ssen        (ssen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vec_n = 0;
  int err_n = 0;

  logic [6:0] font_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // display model state
  int          cyc0;
  logic [11:0] m_d0, m_d1;
  logic [2:0]  m_dp;
  int          m_br;

  typedef struct {
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [18];
  logic [31:0] rd;
  int          acks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the cycle following ready.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rdo);
    bit got;
    got = 1'b0;
    rdo = '0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wd;
    iomem_wstrb = ws;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin
        got = 1'b1;
        rdo = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    chk($sformatf("bus_ack@%0h", addr), {31'd0, got}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_at(input int k, output logic [7:0] ess, output logic [2:0] essen);
    int slot, d, fr;
    logic [11:0] dat;
    logic [3:0]  nib;
    slot = k % 8;
    d    = (k / 8) % 3;
    fr   = k / 24;
    dat  = (fr == 0) ? m_d0 : m_d1;
    nib  = dat[4*d +: 4];
    if (slot < 6) begin
      ess   = ~{m_dp[d], font_t[nib]};
      essen = (slot <= m_br) ? ~(3'b001 << d) : 3'b111;
    end else begin
      ess   = 8'hFF;
      essen = 3'b111;
    end
  endtask

  task automatic run_check(input int n);
    logic [7:0] ess;
    logic [2:0] essen;
    int k;
    repeat (n) begin
      k = cyc - cyc0;
      expect_at(k, ess, essen);
      chk($sformatf("ss_k%0d", k), {24'd0, ss}, {24'd0, ess});
      chk($sformatf("ssen_k%0d", k), {29'd0, ssen}, {29'd0, essen});
      @(negedge clk);
    end
  endtask

  task automatic check_blank(input string name, input int n);
    repeat (n) begin
      chk({name, "_ss"}, {24'd0, ss}, 32'hFF);
      chk({name, "_ssen"}, {29'd0, ssen}, 32'h7);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 4'h4, 32'h0,         4'b0000, CTRL_RST_EXP};
    vt[1]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0};
    vt[2]  = '{1'b0, 4'h8, 32'h0,         4'b0000, 32'h0};
    vt[3]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vt[4]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0FFF};
    vt[5]  = '{1'b1, 4'h0, 32'h0000_0012, 4'b0001, 32'h0};
    vt[6]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0F12};
    vt[7]  = '{1'b1, 4'h0, 32'h0000_0A00, 4'b0010, 32'h0};
    vt[8]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0A12};
    vt[9]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vt[10] = '{1'b0, 4'hC, 32'h0,         4'b0000, 32'h0};
    vt[11] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'b0010, 32'h0};
    vt[12] = '{1'b0, 4'h4, 32'h0,         4'b0000, CTRL_RST_EXP};
    vt[13] = '{1'b1, 4'h4, 32'hFFFF_FF5E, 4'b1111, 32'h0};
    vt[14] = '{1'b0, 4'h4, 32'h0,         4'b0000, BR_BUILT ? 32'h5E : 32'h0E};
    vt[15] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vt[16] = '{1'b0, 4'h8, 32'h0,         4'b0000, 32'h0};
    vt[17] = '{1'b0, 4'h3, 32'h0,         4'b0000, 32'h0000_0A12};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ss", {24'd0, ss}, 32'hFF);
    chk("rst_ssen", {29'd0, ssen}, 32'h7);
    chk("rst_ready", {31'd0, iomem_ready}, 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check_blank("idle", 10);

    // register vectors
    for (int i = 0; i < 18; i++) begin
      bus(BASE + {28'd0, vt[i].off}, vt[i].wdata, vt[i].wstrb, rd);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end
    check_blank("disabled", 4);

    // frame scan with a DATA write during digit 1
    bus(BASE + 32'h0, 32'h0000_0A80, 4'b0011, rd);
    bus(BASE + 32'h4, 32'h0000_00F1, 4'b0001, rd);
    check_blank("enable_lat", 1);
    cyc0 = cyc;
    m_d0 = 12'hA80;
    m_d1 = 12'h111;
    m_dp = 3'b000;
    m_br = 15;
    run_check(10);
    bus(BASE + 32'h0, 32'h0000_0111, 4'b0011, rd);
    run_check(60);

    // disable during digit-0 DRIVE
    chk("pre_disable_ssen", {29'd0, ssen}, 32'h6);
    bus(BASE + 32'h4, 32'h0000_00F0, 4'b0001, rd);
    check_blank("disabled_run", 12);

    // re-enable with dp on digit 0: restarts at digit 0
    bus(BASE + 32'h0, 32'h0, 4'b0011, rd);
    bus(BASE + 32'h4, 32'h0000_00F3, 4'b0001, rd);
    check_blank("reenable_lat", 1);
    cyc0 = cyc;
    m_d0 = 12'h000;
    m_d1 = 12'h000;
    m_dp = 3'b001;
    run_check(24);

    // brightness 0 (full duty when the phase counter is not built)
    bus(BASE + 32'h4, 32'h0, 4'b0001, rd);
    bus(BASE + 32'h4, 32'h0000_0001, 4'b0001, rd);
    check_blank("bright_lat", 1);
    cyc0 = cyc;
    m_dp = 3'b000;
    m_br = BR_BUILT ? 0 : 15;
    run_check(24);
    bus(BASE + 32'h4, 32'h0, 4'b0001, rd);

    // read held valid for 4 cycles: exactly one acknowledge
    acks = 0;
    iomem_addr  = BASE + 32'h8;
    iomem_wstrb = '0;
    iomem_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (iomem_ready) acks++;
    end
    iomem_valid = 1'b0;
    chk("held_read_acks", acks, 1);
    @(posedge clk);
    @(negedge clk);

    // out-of-window address: never acknowledged
    acks = 0;
    iomem_addr  = 32'h0300_0100;
    iomem_wdata = 32'hFFFF_FFFF;
    iomem_wstrb = 4'b1111;
    iomem_valid = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (iomem_ready) acks++;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    chk("bad_addr_acks", acks, 0);
    @(negedge clk);
    bus(BASE + 32'h4, 32'h0, 4'b0000, rd);
    chk("bad_addr_no_write", rd, 32'h0);

    // asynchronous reset while a digit is lit
    bus(BASE + 32'h0, 32'h0000_0321, 4'b0011, rd);
    bus(BASE + 32'h4, 32'h0000_00F1, 4'b0001, rd);
    @(negedge clk);
    chk("pre_reset_ssen", {29'd0, ssen}, 32'h6);
    chk("pre_reset_ss", {24'd0, ss}, 32'hF9);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_ss", {24'd0, ss}, 32'hFF);
    chk("async_rst_ssen", {29'd0, ssen}, 32'h7);
    chk("async_rst_ready", {31'd0, iomem_ready}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bus(BASE + 32'h4, 32'h0, 4'b0000, rd);
    chk("post_rst_ctrl", rd, CTRL_RST_EXP);
    bus(BASE + 32'h0, 32'h0, 4'b0000, rd);
    chk("post_rst_data", rd, 32'h0);
    check_blank("post_rst", 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
